// File: rtl/enc_scan8.sv
// enc_scan8: walks the set bits of an accepted 8-bit request vector and
// emits one binary bit index per valid/ready handshake. The scan runs from
// bit 0 upward by default, or from bit 7 downward when MSB_FIRST is set.
// An all-zero vector produces no beats and raises a one-cycle zero_err pulse.
module enc_scan8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       code_last,
    output logic       zero_err,
    output logic [3:0] frame_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] FRAME_CNT_MAX = 4'd8;

    state_t     state;
    state_t     state_next;
    logic [7:0] pending;
    logic [2:0] sel_idx;
    logic       one_left;
    logic       accept;
    logic       xfer;

    // Index of the lowest set bit. The loop runs downward so the last hit,
    // which wins, is the lowest one.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Index of the highest set bit. The loop runs upward so the last hit,
    // which wins, is the highest one.
    function automatic logic [2:0] highest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i <= 7; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // The scan order is a fixed elaboration choice; only one encoder is used.
    assign sel_idx = MSB_FIRST ? highest_idx(pending) : lowest_idx(pending);

    // Exactly one bit left: nonzero, and clearing the lowest set bit
    // leaves nothing.
    assign one_left = (pending != 8'h00) && ((pending & (pending - 8'd1)) == 8'h00);

    // State register; the synchronous reset drops any frame in progress.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples its inputs from before the edge, independent of
        // statement order or of other always_ff blocks.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake/output decode from the registered state.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        code_valid = 1'b0;
        code       = 3'd0;
        code_last  = 1'b0;
        accept     = 1'b0;
        xfer       = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                // An empty vector has nothing to emit, so the FSM stays put
                // and only zero_err reports it.
                if (req_valid && (req != 8'h00)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                code_valid = 1'b1;
                code       = sel_idx;
                code_last  = one_left;
                xfer       = code_ready;
                // The final beat returns to IDLE; the next vector can be
                // taken no earlier than the following cycle.
                if (code_ready && one_left) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending vector, beat counter and zero-vector pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 8'h00;
            frame_cnt <= 4'd0;
            zero_err  <= 1'b0;
        end else begin
            // zero_err is high only in the cycle right after an empty accept.
            zero_err <= accept && (req == 8'h00);

            if (accept) begin
                pending   <= req;
                frame_cnt <= 4'd0;
            end else if (xfer) begin
                // Retire the bit just handed downstream. A stalled beat
                // (code_ready low) leaves pending, and so code, untouched.
                pending <= pending & ~(8'd1 << sel_idx);
                if (frame_cnt != FRAME_CNT_MAX) begin
                    frame_cnt <= frame_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_enc_scan8.sv
// Testbench for enc_scan8: one instance per scan order sharing the same
// stimulus. Each instance has its own queue of expected beats, filled when a
// vector is offered and drained by a negedge monitor as beats transfer.
module tb_enc_scan8;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       req_valid;
    logic       code_ready;

    logic       ready0, cv0, last0, ze0;
    logic [2:0] code0;
    logic [3:0] fc0;
    logic       ready1, cv1, last1, ze1;
    logic [2:0] code1;
    logic [3:0] fc1;

    beat_t q0[$];
    beat_t q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc_scan8 #(.MSB_FIRST(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_valid (req_valid),
        .req_ready (ready0),
        .code      (code0),
        .code_valid(cv0),
        .code_ready(code_ready),
        .code_last (last0),
        .zero_err  (ze0),
        .frame_cnt (fc0)
    );

    enc_scan8 #(.MSB_FIRST(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_valid (req_valid),
        .req_ready (ready1),
        .code      (code1),
        .code_valid(cv1),
        .code_ready(code_ready),
        .code_last (last1),
        .zero_err  (ze1),
        .frame_cnt (fc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected beats for both scan orders; n returns the number of set bits.
    task automatic push_expect(input logic [7:0] v, output int n);
        beat_t b;
        int    k;
        n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                b.code = 3'(i);
                b.last = (k == n - 1);
                q0.push_back(b);
                k++;
            end
        end
        k = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                b.code = 3'(i);
                b.last = (k == n - 1);
                q1.push_back(b);
                k++;
            end
        end
    endtask

    // Scoreboard monitors: every presented beat must match the queue head,
    // held beats are re-compared each cycle, transferred beats are popped.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cv0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("unexpected_beat0", 32'(cv0), 32'd0);
            end else begin
                check("code0", 32'(code0), 32'(q0[0].code));
                check("last0", 32'(last0), 32'(q0[0].last));
                if (code_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cv1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_beat1", 32'(cv1), 32'd0);
            end else begin
                check("code1", 32'(code1), 32'(q1[0].code));
                check("last1", 32'(last1), 32'(q1[0].last));
                if (code_ready) void'(q1.pop_front());
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready0"}, 32'(ready0), 32'd1);
        check({tag, "_cv0"},    32'(cv0),    32'd0);
        check({tag, "_code0"},  32'(code0),  32'd0);
        check({tag, "_last0"},  32'(last0),  32'd0);
        check({tag, "_ze0"},    32'(ze0),    32'd0);
        check({tag, "_fc0"},    32'(fc0),    32'd0);
        check({tag, "_ready1"}, 32'(ready1), 32'd1);
        check({tag, "_cv1"},    32'(cv1),    32'd0);
        check({tag, "_fc1"},    32'(fc1),    32'd0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req        = 8'h3C;
        code_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in_reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req       = 8'h00;
        @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!ready0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_send", 32'(ready0), 32'd1);
    endtask

    // Offer one vector, then run the frame to completion. With toggle set,
    // code_ready alternates 1,0,1,0 starting with 1 on the first beat.
    // req_valid is kept high with a different vector while in EMIT; it must
    // be ignored.
    task automatic send(input logic [7:0] vec, input bit toggle);
        int cyc;
        int n;
        int exp_len;
        wait_ready();
        push_expect(vec, n);
        req       = vec;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req        = ~vec;
        code_ready = 1'b1;
        @(negedge clk);
        check("cv_after_accept0", 32'(cv0), 32'(vec != 8'h00));
        check("cv_after_accept1", 32'(cv1), 32'(vec != 8'h00));
        check("zero_err0",        32'(ze0), 32'(vec == 8'h00));
        check("zero_err1",        32'(ze1), 32'(vec == 8'h00));
        check("fc_cleared0",      32'(fc0), 32'd0);
        if (ready0) req_valid = 1'b0;
        cyc = 1;
        while (!ready0 && cyc < 40) begin
            @(posedge clk);
            #1;
            if (toggle) code_ready = ~code_ready;
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        exp_len = (n == 0) ? 1 : (toggle ? 2 * n : n + 1);
        check("frame_len",   32'(cyc), 32'(exp_len));
        check("frame_cnt0",  32'(fc0), 32'(n));
        check("frame_cnt1",  32'(fc1), 32'(n));
        check("ready1_done", 32'(ready1), 32'd1);
        check("q0_drained",  32'(q0.size()), 32'd0);
        check("q1_drained",  32'(q1.size()), 32'd0);
        if (vec == 8'h00) begin
            @(negedge clk);
            check("zero_err_pulse_end", 32'(ze0), 32'd0);
            check("zero_idle_ready",    32'(ready0), 32'd1);
            check("zero_idle_fc",       32'(fc0), 32'd0);
        end
    endtask

    // Reset two beats into an 0xFF frame, with a vector offered during reset.
    task automatic reset_mid_frame();
        int n;
        wait_ready();
        push_expect(8'hFF, n);
        req       = 8'hFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        code_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        code_ready = 1'b0;
        req        = 8'h80;
        req_valid  = 1'b1;
        check("beats_before_rst0", 32'(q0.size()), 32'd6);
        check("beats_before_rst1", 32'(q1.size()), 32'd6);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req       = 8'h00;
        q0.delete();
        q1.delete();
        code_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_abort");
        repeat (3) begin
            @(negedge clk);
            check("no_beat_after_rst", 32'(cv0), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 8'h00;
        req_valid  = 1'b0;
        code_ready = 1'b0;

        do_reset();
        send(8'b1010_0101, 1'b0);
        send(8'h00,        1'b0);
        send(8'hFF,        1'b1);
        send(8'h10,        1'b0);
        send(8'h81,        1'b1);
        reset_mid_frame();
        send(8'h02,        1'b0);
        send(8'hFF,        1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
